max7219_seq: RTL and testbench

Sequencer that drives the byte-wide SPI transmitter on behalf of the MAX7219 LED display driver.
- Issues each register write as a two-byte frame (address byte, then data byte) over the transmitter's req/snt handshake.
- After reset, runs a fixed power-up init sequence, then continuously refreshes the digit registers from a local 8x8 shadow register file written by the monitor logic.
- Sits between the display/formatting logic and the SPI module.

---
 rtl/max7219_seq.sv | 154 +++++++++++++++
 tb/tb_max7219_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_seq.sv
// MAX7219 frame sequencer: power-up init, then periodic digit refresh from a shadow file.
// Optional MAX7219_DIRTY_EN: refresh sends only changed digits and a changed intensity.
module max7219_seq #(
    parameter int         N_DIGITS    = 8,
    parameter logic [7:0] DECODE      = 8'h00,
    parameter int         REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [3:0] intensity,
    output logic       spi_req,
    output logic [7:0] spi_dat,
    input  logic       spi_snt,
    output logic       init_done,
    output logic       busy
);
    localparam int CNT_W = $clog2(REFRESH_DIV + 1);

    typedef enum logic [2:0] {LOAD, ADDR, ADDR_GAP, DATA, DATA_GAP, NEXT, WAIT} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       idx_reg;
    logic [7:0]       data_reg;
    logic [7:0]       spi_dat_reg;
    logic             init_done_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [7:0]       shadow [8];
    logic [7:0]       frame_addr, frame_data;
    logic             frame_skip;
    logic             last_frame;
`ifdef MAX7219_DIRTY_EN
    logic [7:0]       dirty_reg;
    logic [3:0]       last_int_reg;
`endif

    // Frame content for the current index; init and refresh share the index counter.
    always_comb begin
        frame_addr = 8'h00;
        frame_data = 8'h00;
        frame_skip = 1'b0;
        if (!init_done_reg) begin
            case (idx_reg)
                4'd0:    begin frame_addr = 8'h0C; frame_data = 8'h01;            end
                4'd1:    begin frame_addr = 8'h0F; frame_data = 8'h00;            end
                4'd2:    begin frame_addr = 8'h09; frame_data = DECODE;           end
                4'd3:    begin frame_addr = 8'h0B; frame_data = 8'(N_DIGITS - 1); end
                default: begin frame_addr = 8'h0A; frame_data = {4'h0, intensity}; end
            endcase
        end else if (idx_reg < 4'(N_DIGITS)) begin
            frame_addr = {4'h0, idx_reg} + 8'd1;
            frame_data = shadow[idx_reg[2:0]];
`ifdef MAX7219_DIRTY_EN
            frame_skip = !dirty_reg[idx_reg[2:0]];
`endif
        end else begin
            frame_addr = 8'h0A;
            frame_data = {4'h0, intensity};
`ifdef MAX7219_DIRTY_EN
            frame_skip = (intensity == last_int_reg);
`endif
        end
    end

    assign last_frame = init_done_reg ? (idx_reg == 4'(N_DIGITS)) : (idx_reg == 4'd4);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:     state_next = frame_skip ? NEXT : ADDR;
            ADDR:     if (spi_snt)  state_next = ADDR_GAP;
            ADDR_GAP: if (!spi_snt) state_next = DATA;
            DATA:     if (spi_snt)  state_next = DATA_GAP;
            DATA_GAP: if (!spi_snt) state_next = NEXT;
            NEXT:     state_next = (init_done_reg && last_frame) ? WAIT : LOAD;
            WAIT:     if (wait_cnt_reg == CNT_W'(REFRESH_DIV - 1)) state_next = LOAD;
            default:  state_next = LOAD;
        endcase
    end

    assign spi_req   = (state_reg == ADDR) || (state_reg == DATA);
    assign spi_dat   = spi_dat_reg;
    assign init_done = init_done_reg;
    assign busy      = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOAD;
            idx_reg       <= 4'd0;
            data_reg      <= 8'h00;
            spi_dat_reg   <= 8'h00;
            init_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
            wait_cnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != WAIT);
            case (state_reg)
                LOAD: begin
                    if (!frame_skip) begin
                        spi_dat_reg <= frame_addr;
                        data_reg    <= frame_data;
                    end
                end
                ADDR_GAP: if (!spi_snt) spi_dat_reg <= data_reg;
                NEXT: begin
                    wait_cnt_reg <= '0;
                    if (last_frame) begin
                        idx_reg       <= 4'd0;
                        init_done_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 4'd1;
                    end
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    idx_reg      <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) shadow[i] <= 8'h00;
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

`ifdef MAX7219_DIRTY_EN
    // A write landing in the same cycle as the latch keeps the digit dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_reg    <= 8'hFF;
            last_int_reg <= 4'h0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en && (wr_addr == 3'(i)))
                    dirty_reg[i] <= 1'b1;
                else if (state_reg == LOAD && init_done_reg &&
                         idx_reg < 4'(N_DIGITS) && idx_reg == 4'(i))
                    dirty_reg[i] <= 1'b0;
            end
            if (state_reg == LOAD && last_frame && !frame_skip)
                last_int_reg <= intensity;
        end
    end
`endif
endmodule

// File: tb/tb_max7219_seq.sv
// Bench for max7219_seq: SPI responder feeds a byte scoreboard; vector table drives refresh passes.
module tb_max7219_seq;
    localparam int N_DIG = 8;
    localparam int RDIV  = 20;
`ifdef MAX7219_DIRTY_EN
    localparam bit DIRTY = 1'b1;
`else
    localparam bit DIRTY = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] intensity;
    logic       spi_req;
    logic [7:0] spi_dat;
    logic       spi_snt;
    logic       init_done;
    logic       busy;

    max7219_seq #(.N_DIGITS(N_DIG), .DECODE(8'h00), .REFRESH_DIV(RDIV)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .intensity(intensity), .spi_req(spi_req), .spi_dat(spi_dat), .spi_snt(spi_snt),
        .init_done(init_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         proto_err = 0;
    int         extra_hold = 0;
    int         cap_count = 0;
    logic       cap_done [256];
    logic [7:0] exp_q [$];
    logic [7:0] m_shadow [8];
    logic [7:0] m_dirty;
    logic [3:0] m_last_int;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic [3:0] inten;
        int         hold;
        int         exp_gap;
    } vec_t;
    vec_t vec [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // SPI transmitter model: snt 3 cycles after req, released extra_hold cycles after req drops.
    initial begin
        int cnt;
        int hold_cnt;
        logic req_dropped;
        logic [7:0] dat0;
        logic [7:0] e;
        spi_snt = 1'b0;
        cnt = 0; hold_cnt = 0; req_dropped = 1'b0; dat0 = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                spi_snt = 1'b0; cnt = 0; req_dropped = 1'b0;
            end else if (spi_snt) begin
                if (!spi_req) begin
                    req_dropped = 1'b1;
                    if (hold_cnt >= extra_hold) begin
                        spi_snt = 1'b0; req_dropped = 1'b0;
                    end else begin
                        hold_cnt++;
                    end
                end else if (req_dropped) begin
                    proto_err++;
                end
            end else if (spi_req) begin
                if (cnt == 0) dat0 = spi_dat;
                else if (spi_dat !== dat0) proto_err++;
                cnt++;
                if (cnt == 3) begin
                    spi_snt = 1'b1; cnt = 0; hold_cnt = 0;
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL byte_unexpected: got %0h, expected no byte", spi_dat);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("byte%0d", cap_count), spi_dat, e);
                    end
                    if (cap_count < 256) cap_done[cap_count] = init_done;
                    cap_count++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        for (int i = 0; i < 8; i++) m_shadow[i] = 8'h00;
        m_dirty = 8'hFF;
        cap_count = 0;
    endtask

    task automatic push_init();
        exp_q.push_back(8'h0C); exp_q.push_back(8'h01);
        exp_q.push_back(8'h0F); exp_q.push_back(8'h00);
        exp_q.push_back(8'h09); exp_q.push_back(8'h00);
        exp_q.push_back(8'h0B); exp_q.push_back(8'h07);
        exp_q.push_back(8'h0A); exp_q.push_back({4'h0, intensity});
        m_last_int = intensity;
    endtask

    task automatic push_pass();
        for (int d = 0; d < N_DIG; d++) begin
            if (!DIRTY || m_dirty[d]) begin
                exp_q.push_back(8'(d + 1));
                exp_q.push_back(m_shadow[d]);
            end
            m_dirty[d] = 1'b0;
        end
        if (!DIRTY || intensity != m_last_int) begin
            exp_q.push_back(8'h0A);
            exp_q.push_back({4'h0, intensity});
        end
        m_last_int = intensity;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin tick(); n++; end
        check({"drain_", name}, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin tick(); n++; end
        check({"reach_wait_", name}, busy, 1'b0);
    endtask

    initial begin
        int n;
        logic req_in_gap;
        vec[0] = '{1'b0, 3'd0, 8'h00, 4'h3, 0, RDIV};
        vec[1] = '{1'b1, 3'd5, 8'hA5, 4'h3, 0, RDIV};
        vec[2] = '{1'b1, 3'd0, 8'h81, 4'hF, 5, RDIV};
        vec[3] = '{1'b1, 3'd7, 8'hFF, 4'hF, 0, RDIV};
        vec[4] = '{1'b1, 3'd5, 8'h3C, 4'h9, 2, RDIV};
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; intensity = 4'h3;

        // Power-up: reset state, init frames, first full pass without a wait.
        do_reset();
        check("rst_req", spi_req, 1'b0);
        check("rst_dat", spi_dat, 8'h00);
        check("rst_init_done", init_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        push_init();
        push_pass();
        tick();
        check("busy_init", busy, 1'b1);
        wait_drain("p1");
        check("init_done_byte10", cap_done[9], 1'b0);
        check("init_done_byte11", cap_done[10], 1'b1);
        check("init_done_p1", init_done, 1'b1);
        wait_idle("p1");

        // Refresh passes from the vector table; writes land at the start of WAIT.
        for (int i = 0; i < 5; i++) begin
            extra_hold = vec[i].hold;
            intensity  = vec[i].inten;
            if (vec[i].we) begin
                wr_en = 1'b1; wr_addr = vec[i].addr; wr_data = vec[i].data;
                m_shadow[vec[i].addr] = vec[i].data;
                m_dirty[vec[i].addr] = 1'b1;
            end
            push_pass();
            n = 0; req_in_gap = 1'b0;
            while (busy === 1'b0 && n < 500) begin
                if (spi_req) req_in_gap = 1'b1;
                tick();
                wr_en = 1'b0;
                n++;
            end
            check($sformatf("gap_v%0d", i), n, vec[i].exp_gap);
            check($sformatf("req_in_gap_v%0d", i), req_in_gap, 1'b0);
            wait_drain($sformatf("v%0d", i));
            wait_idle($sformatf("v%0d", i));
        end
        extra_hold = 0;

        // Digit write during init shows up in the first pass.
        do_reset();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
        m_shadow[2] = 8'h5A;
        push_init();
        push_pass();
        tick();
        wr_en = 1'b0;
        wait_drain("init_write");

        // Reset during the data byte of digit 3 restarts init with cleared shadows.
        do_reset();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
        m_shadow[2] = 8'h5A;
        push_init();
        push_pass();
        tick();
        wr_en = 1'b0;
        n = 0;
        while (!(exp_q.size() == 13 && spi_req === 1'b0) && n < 2000) begin tick(); n++; end
        n = 0;
        while (spi_req !== 1'b1 && n < 100) begin tick(); n++; end
        check("dat_before_rst", spi_dat, 8'h5A);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) m_shadow[i] = 8'h00;
        m_dirty = 8'hFF;
        tick();
        check("req_drop_on_rst", spi_req, 1'b0);
        check("init_done_cleared", init_done, 1'b0);
        rst = 1'b0;
        push_init();
        push_pass();
        wait_drain("after_rst");
        check("init_done_after_rst", init_done, 1'b1);

        check("protocol_errors", proto_err, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
